// File: rtl/pc_gen_if.sv
// Fetch-address bundle between pc_gen, the redirect/trap sources and instruction fetch.
// With PC_GEN_EPC_EN defined the bundle also carries mret_i and epc_o.
interface pc_gen_if #(
  parameter int unsigned XLEN = 32
);
  logic            stall_i;
  logic            fetch_ready_i;
  logic            redirect_i;
  logic [XLEN-1:0] redirect_target_i;
  logic            trap_i;
  logic            halt_i;
  logic [XLEN-1:0] pc_o;
  logic [XLEN-1:0] pc_next_o;
  logic            pc_valid_o;
  logic            misaligned_o;
  logic            halted_o;
`ifdef PC_GEN_EPC_EN
  logic            mret_i;
  logic [XLEN-1:0] epc_o;
`endif

  modport master (
    input  stall_i, fetch_ready_i, redirect_i, redirect_target_i, trap_i, halt_i,
`ifdef PC_GEN_EPC_EN
    input  mret_i,
    output epc_o,
`endif
    output pc_o, pc_next_o, pc_valid_o, misaligned_o, halted_o
  );

  modport slave (
    output stall_i, fetch_ready_i, redirect_i, redirect_target_i, trap_i, halt_i,
`ifdef PC_GEN_EPC_EN
    output mret_i,
    input  epc_o,
`endif
    input  pc_o, pc_next_o, pc_valid_o, misaligned_o, halted_o
  );
endinterface

// File: rtl/pc_gen.sv
// Program-counter generator: reset vector, increment, stall, redirect, trap and halt.
// Optional PC_GEN_EPC_EN adds an exception-PC register and mret return path.
module pc_gen #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter int unsigned     IALIGN       = 4
) (
  input  logic     clk,
  input  logic     rst,
  pc_gen_if.master bus
);

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_RUN,
    ST_HALTED
  } state_e;

  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(IALIGN - 1);
  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(IALIGN);

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            valid_q, valid_d;
  logic            halted_q, halted_d;
  logic            misaligned_q, misaligned_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic            target_misaligned;
  logic            mret_req;

  assign target_misaligned = |(bus.redirect_target_i & ALIGN_MASK);

`ifdef PC_GEN_EPC_EN
  assign mret_req  = bus.mret_i;
  assign bus.epc_o = epc_q;
`else
  assign mret_req  = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    valid_d      = valid_q;
    halted_d     = halted_q;
    misaligned_d = 1'b0;
    epc_d        = epc_q;
    case (state_q)
      ST_BOOT: begin
        state_d  = ST_RUN;
        valid_d  = 1'b1;
        halted_d = 1'b0;
      end
      ST_RUN: begin
        // Redirect/trap flush past stall and fetch backpressure.
        if (bus.trap_i) begin
          pc_d  = TRAP_VECTOR;
          epc_d = pc_q;
        end else if (mret_req) begin
          pc_d = epc_q;
        end else if (bus.redirect_i) begin
          if (target_misaligned) begin
            pc_d         = TRAP_VECTOR;
            misaligned_d = 1'b1;
            epc_d        = pc_q;
          end else begin
            pc_d = bus.redirect_target_i;
          end
        end else if (bus.halt_i) begin
          state_d  = ST_HALTED;
          valid_d  = 1'b0;
          halted_d = 1'b1;
        end else if (!bus.stall_i && bus.fetch_ready_i) begin
          pc_d = pc_q + PC_STEP;
        end
      end
      ST_HALTED: begin
        if (bus.trap_i) begin
          state_d  = ST_RUN;
          pc_d     = TRAP_VECTOR;
          valid_d  = 1'b1;
          halted_d = 1'b0;
          epc_d    = pc_q;
        end
      end
      default: begin
        state_d  = ST_BOOT;
        pc_d     = RESET_VECTOR;
        valid_d  = 1'b0;
        halted_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_BOOT;
      pc_q         <= RESET_VECTOR;
      valid_q      <= 1'b0;
      halted_q     <= 1'b0;
      misaligned_q <= 1'b0;
      epc_q        <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      valid_q      <= valid_d;
      halted_q     <= halted_d;
      misaligned_q <= misaligned_d;
      epc_q        <= epc_d;
    end
  end

  assign bus.pc_o         = pc_q;
  assign bus.pc_next_o    = rst ? RESET_VECTOR : pc_d;
  assign bus.pc_valid_o   = valid_q;
  assign bus.halted_o     = halted_q;
  assign bus.misaligned_o = misaligned_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed-vector bench for pc_gen; expected values are hand-computed constants.
module tb_pc_gen;

  logic clk = 1'b0;
  logic rst;
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  pc_gen_if #(.XLEN(32)) bus ();

  pc_gen #(
    .XLEN        (32),
    .RESET_VECTOR(32'h0000_0000),
    .TRAP_VECTOR (32'h0000_0100),
    .IALIGN      (4)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.stall_i           = 1'b0;
    bus.fetch_ready_i     = 1'b1;
    bus.redirect_i        = 1'b0;
    bus.redirect_target_i = '0;
    bus.trap_i            = 1'b0;
    bus.halt_i            = 1'b0;
`ifdef PC_GEN_EPC_EN
    bus.mret_i            = 1'b0;
`endif
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    step();
    check("rst_pc", bus.pc_o, 32'h0);
    check("rst_valid", 32'(bus.pc_valid_o), 32'h0);
    check("rst_halted", 32'(bus.halted_o), 32'h0);
    check("rst_mis", 32'(bus.misaligned_o), 32'h0);
    check("rst_pc_next", bus.pc_next_o, 32'h0);
`ifdef PC_GEN_EPC_EN
    check("rst_epc", bus.epc_o, 32'h0);
`endif
    rst = 1'b0;
    #1;
    check("boot_pc_next", bus.pc_next_o, 32'h0);
    step();
    check("boot_pc", bus.pc_o, 32'h0);
    check("boot_valid", 32'(bus.pc_valid_o), 32'h1);
    step(); check("run_pc4", bus.pc_o, 32'h4);
    step(); check("run_pc8", bus.pc_o, 32'h8);
    step(); check("run_pcC", bus.pc_o, 32'hC);
    step(); check("run_pc10", bus.pc_o, 32'h10);

    bus.stall_i = 1'b1;
    #1;
    check("stall_pc_next", bus.pc_next_o, 32'h10);
    for (int i = 0; i < 3; i++) begin
      step(); check("stall_hold", bus.pc_o, 32'h10);
    end
    bus.stall_i = 1'b0;
    step(); check("stall_resume", bus.pc_o, 32'h14);
    bus.fetch_ready_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step(); check("notready_hold", bus.pc_o, 32'h14);
    end
    bus.fetch_ready_i = 1'b1;
    step(); check("ready_resume", bus.pc_o, 32'h18);

    bus.stall_i = 1'b1;
    bus.redirect_i = 1'b1;
    bus.redirect_target_i = 32'h200;
    step();
    check("redir_pc", bus.pc_o, 32'h200);
    check("redir_mis", 32'(bus.misaligned_o), 32'h0);
    bus.redirect_target_i = 32'h302;
    step();
    check("misal_pc", bus.pc_o, 32'h100);
    check("misal_pulse1", 32'(bus.misaligned_o), 32'h1);
`ifdef PC_GEN_EPC_EN
    check("misal_epc", bus.epc_o, 32'h200);
`endif
    bus.redirect_target_i = 32'h301;
    step();
    check("misal2_pc", bus.pc_o, 32'h100);
    check("misal_pulse2", 32'(bus.misaligned_o), 32'h1);
    clear_inputs();
    step();
    check("misal_clear_pc", bus.pc_o, 32'h104);
    check("misal_clear", 32'(bus.misaligned_o), 32'h0);

    bus.redirect_i = 1'b1;
    bus.redirect_target_i = 32'hFFFF_FFFC;
    step();
    check("wrap_top", bus.pc_o, 32'hFFFF_FFFC);
    clear_inputs();
    #1;
    check("wrap_pc_next", bus.pc_next_o, 32'h0);
    step();
    check("wrap_zero", bus.pc_o, 32'h0);
    check("wrap_mis", 32'(bus.misaligned_o), 32'h0);
    check("wrap_halted", 32'(bus.halted_o), 32'h0);
    check("wrap_valid", 32'(bus.pc_valid_o), 32'h1);
    step(); check("wrap_pc4", bus.pc_o, 32'h4);

    bus.redirect_i = 1'b1;
    bus.redirect_target_i = 32'h40;
    step(); check("pre_halt_pc", bus.pc_o, 32'h40);
    clear_inputs();
    bus.halt_i = 1'b1;
    step();
    check("halt_pc", bus.pc_o, 32'h40);
    check("halt_flag", 32'(bus.halted_o), 32'h1);
    check("halt_valid", 32'(bus.pc_valid_o), 32'h0);
    clear_inputs();
    bus.redirect_i = 1'b1;
    bus.redirect_target_i = 32'h200;
    bus.stall_i = 1'b1;
    step();
    check("halt_ign_redir", bus.pc_o, 32'h40);
    check("halt_still", 32'(bus.halted_o), 32'h1);
    clear_inputs();
    bus.trap_i = 1'b1;
    step();
    check("halt_trap_pc", bus.pc_o, 32'h100);
    check("halt_trap_flag", 32'(bus.halted_o), 32'h0);
    check("halt_trap_valid", 32'(bus.pc_valid_o), 32'h1);
`ifdef PC_GEN_EPC_EN
    check("halt_trap_epc", bus.epc_o, 32'h40);
`endif
    clear_inputs();
    step(); check("post_trap_pc", bus.pc_o, 32'h104);

    bus.halt_i = 1'b1;
    bus.redirect_i = 1'b1;
    bus.redirect_target_i = 32'h300;
    step();
    check("halt_redir_pc", bus.pc_o, 32'h300);
    check("halt_redir_flag", 32'(bus.halted_o), 32'h0);
    clear_inputs();
    step(); check("halt_dropped_pc", bus.pc_o, 32'h304);

    bus.trap_i = 1'b1;
    bus.redirect_i = 1'b1;
    bus.redirect_target_i = 32'h502;
    step();
    check("trap_prio_pc", bus.pc_o, 32'h100);
    check("trap_prio_mis", 32'(bus.misaligned_o), 32'h0);
    clear_inputs();

`ifdef PC_GEN_EPC_EN
    bus.redirect_i = 1'b1;
    bus.redirect_target_i = 32'h80;
    step(); check("epc_pre_pc", bus.pc_o, 32'h80);
    clear_inputs();
    bus.trap_i = 1'b1;
    step();
    check("epc_trap_pc", bus.pc_o, 32'h100);
    check("epc_value", bus.epc_o, 32'h80);
    clear_inputs();
    bus.mret_i = 1'b1;
    step(); check("mret_pc", bus.pc_o, 32'h80);
    clear_inputs();
`endif

    bus.redirect_i = 1'b1;
    bus.redirect_target_i = 32'h80;
    step(); check("pre_rst_pc", bus.pc_o, 32'h80);
    clear_inputs();
    rst = 1'b1;
    bus.trap_i = 1'b1;
    #1;
    check("rst_trap_pc_next", bus.pc_next_o, 32'h0);
    step();
    check("rst_trap_pc", bus.pc_o, 32'h0);
    check("rst_trap_valid", 32'(bus.pc_valid_o), 32'h0);
    rst = 1'b0;
    step();
    check("boot_ign_trap_pc", bus.pc_o, 32'h0);
    check("boot_ign_valid", 32'(bus.pc_valid_o), 32'h1);
    clear_inputs();
    step(); check("reboot_pc4", bus.pc_o, 32'h4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
